// File: rtl/mb8_word_ctl.sv
// mb8_word_ctl: byte/word load-store sequencer for the 8-bit mb8_io memory bus.
// Define MB8_LITTLE_ENDIAN_EN for little-endian word layout (default big-endian).
module mb8_word_ctl #(
    parameter int ASZ = 17
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic           req_word,
    input  logic [ASZ-1:0] req_addr,
    input  logic [15:0]    req_wdata,
    output logic           rsp_valid,
    output logic [15:0]    rsp_data,
    output logic [ASZ-1:0] ai,
    output logic [7:0]     vi,
    output logic           we,
    input  logic [7:0]     vo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_B0   = 2'd1;
    localparam logic [1:0] S_B1   = 2'd2;
    localparam logic [1:0] S_RCAP = 2'd3;

    localparam logic [ASZ-1:0] ONE = 1;

    logic [1:0]  state;
    logic        word_q;
    logic [7:0]  second_q;
    logic [7:0]  first_q;
    logic [7:0]  first_byte;
    logic [7:0]  second_byte;
    logic [15:0] word_data;

    assign req_ready = (state == S_IDLE);

    // Store data split into bus order: byte for A, then byte for A+1
    always_comb begin
`ifdef MB8_LITTLE_ENDIAN_EN
        first_byte  = req_wdata[7:0];
        second_byte = req_wdata[15:8];
`else
        first_byte  = req_word ? req_wdata[15:8] : req_wdata[7:0];
        second_byte = req_wdata[7:0];
`endif
    end

    // Word load result from mem[A] (first_q) and mem[A+1] (vo)
    always_comb begin
`ifdef MB8_LITTLE_ENDIAN_EN
        word_data = {vo, first_q};
`else
        word_data = {first_q, vo};
`endif
    end

    // Sequencer: issue one or two byte cycles, capture read data one cycle late
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ai        <= '0;
            vi        <= '0;
            we        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            word_q    <= 1'b0;
            second_q  <= '0;
            first_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ai       <= req_addr;
                        we       <= req_we;
                        vi       <= first_byte;
                        word_q   <= req_word;
                        second_q <= second_byte;
                        state    <= S_B0;
                    end
                end
                S_B0: begin
                    if (word_q) begin
                        ai    <= ai + ONE;
                        vi    <= second_q;
                        state <= S_B1;
                    end else if (we) begin
                        we        <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_RCAP;
                    end
                end
                S_B1: begin
                    if (we) begin
                        we        <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        first_q <= vo;
                        state   <= S_RCAP;
                    end
                end
                S_RCAP: begin
                    rsp_data  <= word_q ? word_data : {8'h00, vo};
                    rsp_valid <= 1'b1;
                    we        <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mb8_word_ctl.md
# mb8_word_ctl

Bus-master sequencer for the 8-bit single-port memory bus (`mb8_io` protocol, 128K `spram8_128k`). It accepts byte or 16-bit word load/store requests from the eForth1 core and issues one or two byte cycles on `ai`/`vi`/`we`. For loads it captures `vo` under the memory's one-cycle synchronous-read latency and returns the assembled result. It sits between the core's fetch/store path and the memory slave port.

## Interface
Parameters:
- `ASZ`, 17: memory address width in bits (128K bytes).

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted at a posedge where `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_word`  in  1  1 = 16-bit word, 0 = single byte.
- `req_addr`  in  ASZ  byte address.
- `req_wdata`  in  16  store data; bytes use `[7:0]`.
- `rsp_valid`  out  1  one-cycle completion pulse for loads and stores.
- `rsp_data`  out  16  load result; byte loads zero-extend.
- `ai`  out  ASZ  memory address, registered.
- `vi`  out  8  memory write data, registered.
- `we`  out  1  memory write enable, registered.
- `vo`  in  8  memory read data, valid the cycle after the `ai` it answers was sampled.

One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- States:
  - IDLE: `req_ready`=1.
  - B0: first byte on bus.
  - B1: second byte of a word.
  - RCAP: trailing load capture.
- `req_ready` = (state == IDLE). There is no backpressure on `rsp_valid`.
- On accept:
  - Latch the request.
  - Drive `ai`=A.
  - Set `we`=`req_we`.
  - Set `vi`=first byte (stores).
  - Go to B0.
- Byte order (default, big-endian): word high byte at A, low byte at A+1.
- Second byte address is (A+1) mod 2^ASZ, so 0x1FFFF+1 wraps to 0x00000.
- B0 →:
  - Word: go to B1 with `ai`=A+1 and `vi`=second byte.
  - Byte store: go to IDLE with `we`=0 and `rsp_valid`=1.
  - Byte load: go to RCAP.
- B1 →:
  - Store: go to IDLE with `we`=0 and `rsp_valid`=1.
  - Load: capture `vo` (=mem[A]) as first byte, then go to RCAP.
- RCAP → IDLE:
  - Capture `vo` as the last byte and assemble `rsp_data`.
  - Set `rsp_valid`=1.
  - Set `we`=0.
- `ai` and `vi` hold their last values in IDLE; `we` is 0 in IDLE.
- `rsp_data` holds until the next load completes. Stores do not change it.
- Reset (async, any state): state=IDLE, `ai`=0, `vi`=0, `we`=0, `rsp_valid`=0, `rsp_data`=0.
- A reset mid-word-store may leave only the first byte written. This is accepted and not recovered.

## Timing
Latencies are counted from the accept edge E0; `rsp_valid` is high in the cycle after edge En.
- Byte store: memory writes at E1; `rsp_valid` after E1 (latency 1).
- Word store: writes at E1 and E2; `rsp_valid` after E2 (latency 2).
- Byte load: memory samples A at E1; `vo` is captured at E2; `rsp_valid` after E2 (latency 2).
- Word load: memory samples A at E1 and A+1 at E2; captures at E2 and E3; `rsp_valid` after E3 (latency 3).
- `req_ready` rises in the same cycle as `rsp_valid`, so back-to-back requests have one cycle of bus idle between them.
- `req_*` signals are don't-care outside the accept edge.

## Configuration
- `MB8_LITTLE_ENDIAN_EN` undefined (default): big-endian. Word store writes `req_wdata[15:8]` to A; word load gives `rsp_data` = {mem[A], mem[A+1]}.
- `MB8_LITTLE_ENDIAN_EN` defined: little-endian. `req_wdata[7:0]` goes to A; `rsp_data` = {mem[A+1], mem[A]}.
- Byte accesses and timing are identical in both modes.

## Test plan
- Reset then idle:
  - `rst_n` low mid-simulation → `we`=0, `rsp_valid`=0, `ai`=0 immediately (asynchronous).
  - After release → `req_ready`=1.
- Word store then load at 0x00100 with data 0x1234:
  - Bus shows `ai`=0x00100/`vi`=0x12/`we`=1, then 0x00101/0x34/1.
  - `rsp_valid` appears 2 cycles after accept.
  - The load returns `rsp_data`=0x1234 3 cycles after accept.
- Byte store 0xA5 to 0x00042, then byte load of 0x00042 → `rsp_data`=0x00A5 with latency 2; 0x00043 is unchanged.
- Wrap-around: word store 0xBEEF to 0x1FFFF → bytes go to 0x1FFFF=0xBE and 0x00000=0xEF; a word load of 0x1FFFF returns 0xBEEF.
- Back-to-back: `req_valid` held high with 4 word loads → each accepted in the `rsp_valid` cycle of the previous one; `ai` sequence A, A+1, idle, B, B+1, …; no request lost.
- With `MB8_LITTLE_ENDIAN_EN`: word store 0x1234 to 0x00200 → mem[0x200]=0x34, mem[0x201]=0x12; the load returns 0x1234.
